// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a valid/ready result handshake.
// Define MULDIV_FAST_MUL_EN to resolve multiplies with one combinational product on acceptance.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [5:0]      alu_control,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   b_q;

    // Request decode, evaluated on the input operands while idle
    logic            op_ok, in_div, sgn1, sgn2, neg1, neg2, in_neg;
    logic [XLEN-1:0] mag1, mag2;
    logic            spec_hit;
    logic [XLEN-1:0] spec_val;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
`endif

    always_comb begin
        op_ok    = (alu_control[5:3] == 3'b010);
        in_div   = alu_control[2];
        sgn1     = in_div ? ~alu_control[0] : (alu_control[1] ^ alu_control[0]);
        sgn2     = in_div ? ~alu_control[0] : (alu_control[1:0] == 2'b01);
        neg1     = sgn1 & operand1[XLEN-1];
        neg2     = sgn2 & operand2[XLEN-1];
        mag1     = neg1 ? -operand1 : operand1;
        mag2     = neg2 ? -operand2 : operand2;
        // Remainder follows the dividend; product and quotient follow the sign difference
        in_neg   = (in_div && alu_control[1]) ? neg1 : (neg1 ^ neg2);
        spec_hit = 1'b0;
        spec_val = '0;
`ifdef MULDIV_FAST_MUL_EN
        fast_a    = {{XLEN{neg1}}, operand1};
        fast_b    = {{XLEN{neg2}}, operand2};
        fast_prod = fast_a * fast_b;
`endif
        if (!op_ok) begin
            spec_hit = 1'b1;
        end else if (in_div && operand2 == '0) begin
            spec_hit = 1'b1;
            spec_val = alu_control[1] ? operand1 : '1;
        end else if (in_div && !alu_control[0] && operand1 == IntMin && operand2 == '1) begin
            spec_hit = 1'b1;
            spec_val = alu_control[1] ? '0 : IntMin;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!in_div) begin
            spec_hit = 1'b1;
            spec_val = (alu_control[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                   : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // One radix-2 step of either datapath plus the sign-corrected final value
    logic [XLEN:0]     mul_sum, trial;
    logic [XLEN-1:0]   diff_lo;
    logic              ge;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   mul_res, div_sel, div_res, fin;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        trial    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        ge       = (trial >= {1'b0, b_q});
        diff_lo  = trial[XLEN-1:0] - b_q;
        div_next = ge ? {diff_lo, acc_q[XLEN-2:0], 1'b1}
                      : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        prod     = neg_q ? -mul_next : mul_next;
        mul_res  = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        div_sel  = op_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
        div_res  = neg_q ? -div_sel : div_sel;
        fin      = op_q[2] ? div_res : mul_res;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            op_q         <= '0;
            neg_q        <= 1'b0;
            acc_q        <= '0;
            b_q          <= '0;
            op_ready     <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else if (flush) begin
            state_q      <= StIdle;
            op_ready     <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (op_valid) begin
                        op_ready <= 1'b0;
                        busy     <= 1'b1;
                        op_q     <= alu_control[2:0];
                        neg_q    <= in_neg;
                        cnt_q    <= '0;
                        if (spec_hit) begin
                            result  <= spec_val;
                            state_q <= StDone;
                        end else begin
                            // Multiplier sits in the low half; dividend shifts out of the low half
                            acc_q   <= {{XLEN{1'b0}}, in_div ? mag1 : mag2};
                            b_q     <= in_div ? mag2 : mag1;
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1)) begin
                        result  <= fin;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (!result_valid) begin
                        result_valid <= 1'b1;
                    end else if (result_ready) begin
                        result_valid <= 1'b0;
                        op_ready     <= 1'b1;
                        busy         <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset, op_valid, op_ready, flush, result_valid, result_ready, busy;
    logic [5:0]  alu_control;
    logic [31:0] operand1, operand2, result;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .alu_control  (alu_control),
        .operand1     (operand1),
        .operand2     (operand2),
        .flush        (flush),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib, iq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        p  = '0;
        iq = 0;
        case (op)
            6'b010000: begin p = ua * ub; return p[31:0]; end
            6'b010001: begin p = sa * sb; return p[63:32]; end
            6'b010010: begin p = sa * ub; return p[63:32]; end
            6'b010011: begin p = ua * ub; return p[63:32]; end
            6'b010100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                iq = ia / ib;
                return iq;
            end
            6'b010101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            6'b010110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                iq = ia % ib;
                return iq;
            end
            6'b010111: return (b == 0) ? a : a % b;
            default:   return 32'h0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[5:3] != 3'b010) return 1;
        if (op[2] && b == 0) return 1;
        if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Presents one request and returns just after its acceptance edge
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!op_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 100) check_eq("op_ready_timeout", {63'b0, op_ready}, 64'd1);
        @(negedge clk);
        op_valid = 1'b1; alu_control = op; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        op_valid = 1'b0; alu_control = 6'($urandom); operand1 = $urandom; operand2 = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!result_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk); result_ready = 1'b1;
        @(posedge clk); #1; result_ready = 1'b0;
        check_eq("post_handshake_valid", {63'b0, result_valid}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        issue(op, a, b);
        wait_valid(lat);
        check_eq({tag, "_lat"}, lat, exp_lat(op, a, b));
        check_eq(tag, result, exp);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 check_eq({tag, "_hold"}, result, exp);
        consume();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, seen;
        logic [5:0]  op;
        logic [31:0] a, b;
        reset = 1'b1; op_valid = 1'b0; flush = 1'b0; result_ready = 1'b0;
        alu_control = '0; operand1 = '0; operand2 = '0;
        #1;
        check_eq("rst_op_ready", {63'b0, op_ready}, 64'd1);
        check_eq("rst_valid", {63'b0, result_valid}, 64'd0);
        check_eq("rst_busy", {63'b0, busy}, 64'd0);
        check_eq("rst_result", result, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        run_op("mul_7x-3", 6'b010000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh", 6'b010001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhsu", 6'b010010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("mulhu", 6'b010011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
        run_op("div_-7/2", 6'b010100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_-7/2", 6'b010110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu", 6'b010101, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF);
        run_op("div_by0", 6'b010100, 32'd1234, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_by0", 6'b010111, 32'd5, 32'd0, 32'd5);
        run_op("div_ovf", 6'b010100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", 6'b010110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_op("bad_op", 6'b011000, 32'd9, 32'd9, 32'h0);

        // Result held while the consumer stalls; new requests are ignored
        issue(6'b010101, 32'd100, 32'd7);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); op_valid = 1'b1; alu_control = 6'b010000; operand1 = 32'd3;
            @(posedge clk); #1;
            check_eq("stall_result", result, 64'd14);
            check_eq("stall_valid", {63'b0, result_valid}, 64'd1);
            check_eq("stall_op_ready", {63'b0, op_ready}, 64'd0);
        end
        @(negedge clk); op_valid = 1'b0;
        consume();

        // Flush at iteration 10 of a divide
        issue(6'b010100, 32'd1000, 32'hFFFF_FFFD);
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        check_eq("flush_busy", {63'b0, busy}, 64'd0);
        check_eq("flush_op_ready", {63'b0, op_ready}, 64'd1);
        @(negedge clk); flush = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (result_valid) seen++;
        end
        check_eq("flush_no_result", seen, 0);
        run_op("after_flush", 6'b010110, 32'd1000, 32'hFFFF_FFFD, 32'd1);

        // Flush while idle blocks acceptance
        @(negedge clk); flush = 1'b1; op_valid = 1'b1; alu_control = 6'b010100;
        @(posedge clk); #1;
        check_eq("idle_flush_busy", {63'b0, busy}, 64'd0);
        @(negedge clk); flush = 1'b0; op_valid = 1'b0;

        // Flush together with result_ready in DONE
        issue(6'b010100, 32'd8, 32'd0);
        wait_valid(lat);
        @(negedge clk); flush = 1'b1; result_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("flush_rdy_valid", {63'b0, result_valid}, 64'd0);
        check_eq("flush_rdy_op_ready", {63'b0, op_ready}, 64'd1);
        @(negedge clk); flush = 1'b0; result_ready = 1'b0;

        // Asynchronous reset mid-CALC
        issue(6'b010101, 32'd77, 32'd5);
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_eq("areset_op_ready", {63'b0, op_ready}, 64'd1);
        check_eq("areset_busy", {63'b0, busy}, 64'd0);
        check_eq("areset_result", result, 64'd0);
        @(negedge clk); reset = 1'b0;
        run_op("after_reset", 6'b010011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        for (int i = 0; i < 60; i++) begin
            op = (i % 12 == 11) ? 6'($urandom) : {3'b010, 3'($urandom)};
            a  = rnd_operand();
            b  = rnd_operand();
            run_op($sformatf("rnd%0d_op%0h", i, op), op, a, b, ref_result(op, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
